stream_fifo: RTL and testbench
==============================

STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter Size, default 4: number of entries; any integer >= 2, power of two not required.
REQ-002 SHALL have parameter Width, default 8: data bits per entry, >= 1.
REQ-003 SHALL have parameter Mode, default FifoStandard: fifo_mode_e; FifoStandard = registered read, FifoFwft = first-word-fall-through.
REQ-004 SHALL have parameter AlmostFullLevel, default Size-1: almost_full_o threshold, range 1..Size.
REQ-005 SHALL have parameter AlmostEmptyLevel, default 1: almost_empty_o threshold, range 0..Size-1.
REQ-006 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port flush_i, input, 1: synchronous clear of contents.
REQ-009 SHALL have port write_req_i, input, 1: producer requests a push.
REQ-010 SHALL have port write_valid_o, output, 1: FIFO can accept a push this cycle (not full).
REQ-011 SHALL have port data_i, input, Width: push data.
REQ-012 SHALL have port read_req_i, input, 1: consumer requests a pop.
REQ-013 SHALL have port read_valid_o, output, 1: FIFO can supply a pop this cycle (not empty).
REQ-014 SHALL have port data_o, output, Width: pop data; timing per Mode.
REQ-015 SHALL have port count_o, output, $clog2(Size+1): current occupancy.
REQ-016 SHALL have port almost_full_o, output, 1: count_o >= AlmostFullLevel.
REQ-017 SHALL have port almost_empty_o, output, 1: count_o <= AlmostEmptyLevel.

Function
REQ-018 SHALL accept a push iff write_req_i && write_valid_o, and a pop iff read_req_i && read_valid_o; requests without valid are ignored with no state change.
REQ-019 SHALL derive write_valid_o = (count != Size) and read_valid_o = (count != 0), both from registered state only, with no combinational path from any request input.
REQ-020 SHALL update count each cycle as count + push - pop; a simultaneous push and pop leaves count unchanged.
REQ-021 SHALL advance the read and write indices by 1 on pop and push respectively, wrapping from Size-1 to 0 for any Size.
REQ-022 SHALL reject a push when full even if a pop occurs in the same cycle, and reject a pop when empty even if a push occurs in the same cycle (no bypass).
REQ-023 In FifoStandard mode, SHALL load data_o with the head entry on the edge that accepts a pop (one-cycle latency), and SHALL otherwise hold data_o.
REQ-024 In FifoFwft mode, SHALL drive data_o with the head entry whenever read_valid_o=1; an accepted pop presents the next entry on the following cycle. data_o is don't-care while read_valid_o=0.
REQ-025 SHALL make a push into an empty FIFO visible (read_valid_o=1, FWFT data_o valid) on the cycle after the push.
REQ-026 SHALL derive almost_full_o and almost_empty_o combinationally from registered count only.
REQ-027 When flush_i=1, SHALL zero the indices and count on that edge, discard any push or pop in that cycle, and leave data_o and memory contents unchanged.

Reset
REQ-028 While rst_i=1, SHALL on each rising edge zero the indices and count and set data_o=0. Reset takes priority over flush_i and all requests.
REQ-029 After reset, outputs SHALL be: write_valid_o=1, read_valid_o=0, count_o=0, almost_empty_o=1, and almost_full_o=0.
REQ-030 Reset asserted mid-transfer SHALL drop all stored entries; memory need not be cleared.

Structure
REQ-031 SHALL take fifo_mode_e {FifoStandard, FifoFwft} and a count-width function from shared package fifo_pkg.
REQ-032 SHALL place storage in sub-module fifo_ram: parameters Size and Width, one synchronous write port, one combinational read port. Mode-specific output registering SHALL live in stream_fifo.

Verification
REQ-033 Size=3, Width=8, Standard: push 0x11, 0x22, 0x33 -> write_valid_o=0 and count_o=3. Three pops -> data_o shows 0x11, 0x22, 0x33, each one cycle after its pop; read_valid_o=0.
REQ-034 Size=3, wrap: 10 push/pop pairs with data 0..9 -> output order 0..9 and count_o never exceeds 3.
REQ-035 Full FIFO with push+pop in the same cycle -> pop accepted, push ignored, count_o 3->2. Empty FIFO with push+pop -> push accepted, count_o 0->1.
REQ-036 Size=4, FifoFwft: push 0xA5 -> next cycle read_valid_o=1 and data_o=0xA5 with no pop. Pop -> read_valid_o=0.
REQ-037 Size=4, levels 3/1: fill to 3 -> almost_full_o rises at count 3, and almost_empty_o falls when count reaches 2.
REQ-038 count=2 with flush_i and write_req_i both high -> next cycle count_o=0 and data_o unchanged. rst_i mid-fill -> count_o=0 and data_o=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO types and sizing helpers
package fifo_pkg;

  typedef enum logic {
    FifoStandard = 1'b0,
    FifoFwft     = 1'b1
  } fifo_mode_e;

  // Bits needed to hold an occupancy of 0..size inclusive.
  function automatic int count_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// rtl/stream_fifo_if.sv - producer/consumer handshake bundle for stream_fifo
interface stream_fifo_if #(
  parameter int Width  = 8,
  parameter int CountW = 3
);

  logic              write_req_i;
  logic              write_valid_o;
  logic [Width-1:0]  data_i;
  logic              read_req_i;
  logic              read_valid_o;
  logic [Width-1:0]  data_o;
  logic [CountW-1:0] count_o;
  logic              almost_full_o;
  logic              almost_empty_o;

  modport master (
    output write_req_i, data_i, read_req_i,
    input  write_valid_o, read_valid_o, data_o, count_o, almost_full_o, almost_empty_o
  );

  modport slave (
    input  write_req_i, data_i, read_req_i,
    output write_valid_o, read_valid_o, data_o, count_o, almost_full_o, almost_empty_o
  );

endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - FIFO storage: one synchronous write port, one combinational read port
module fifo_ram #(
  parameter int Size  = 4,
  parameter int Width = 8,
  parameter int AddrW = $clog2(Size)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Size];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - synchronous FIFO with standard or first-word-fall-through read timing
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int         Size             = 4,
  parameter int         Width            = 8,
  parameter fifo_mode_e Mode             = FifoStandard,
  parameter int         AlmostFullLevel  = Size - 1,
  parameter int         AlmostEmptyLevel = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  stream_fifo_if.slave bus
);

  localparam int CountW = count_width(Size);
  localparam int AddrW  = $clog2(Size);

  logic [AddrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic [Width-1:0]  dout_q, dout_d;
  logic [Width-1:0]  ram_rdata;
  logic              full, empty, push, pop;

  function automatic logic [AddrW-1:0] next_ptr(input logic [AddrW-1:0] p);
    return (p == AddrW'(Size - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CountW'(Size));
  assign empty = (count_q == '0);

  // Flush discards same-cycle requests, so it gates both handshakes here.
  assign push = bus.write_req_i & ~full  & ~flush_i;
  assign pop  = bus.read_req_i  & ~empty & ~flush_i;

  fifo_ram #(
    .Size  (Size),
    .Width (Width),
    .AddrW (AddrW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (bus.data_i),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CountW'(push) - CountW'(pop);
    dout_d  = dout_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = next_ptr(wptr_q);
      if (pop) begin
        rptr_d = next_ptr(rptr_q);
        if (Mode == FifoStandard) dout_d = ram_rdata;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.write_valid_o  = ~full;
  assign bus.read_valid_o   = ~empty;
  assign bus.count_o        = count_q;
  assign bus.almost_full_o  = (count_q >= CountW'(AlmostFullLevel));
  assign bus.almost_empty_o = (count_q <= CountW'(AlmostEmptyLevel));
  // FWFT shows the head straight from storage; dout_q stays at its reset value there.
  assign bus.data_o = (Mode == FifoFwft && !empty) ? ram_rdata : dout_q;

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - randomized and directed checks of stream_fifo against a queue model
module tb_stream_fifo;
  import fifo_pkg::*;

  localparam int SA = 3;
  localparam int SB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, flush_a, rst_b, flush_b;

  stream_fifo_if #(.Width(8), .CountW(count_width(SA))) ifa ();
  stream_fifo_if #(.Width(8), .CountW(count_width(SB))) ifb ();

  stream_fifo #(.Size(SA), .Width(8), .Mode(FifoStandard)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .flush_i(flush_a), .bus(ifa.slave)
  );

  stream_fifo #(.Size(SB), .Width(8), .Mode(FifoFwft),
                .AlmostFullLevel(3), .AlmostEmptyLevel(1)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .flush_i(flush_b), .bus(ifb.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] da = 8'h00;
  int max_cnt_a = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock on unit u (0 = Size 3 standard, 1 = Size 4 FWFT); the other unit idles.
  task automatic step(input int u, input bit rst, input bit fl, input bit wr,
                      input bit rd, input logic [7:0] d);
    int n, cap;
    bit push, pop;
    rst_a = 0; flush_a = 0; ifa.write_req_i = 0; ifa.read_req_i = 0; ifa.data_i = 8'h00;
    rst_b = 0; flush_b = 0; ifb.write_req_i = 0; ifb.read_req_i = 0; ifb.data_i = 8'h00;
    if (u == 0) begin
      rst_a = rst; flush_a = fl; ifa.write_req_i = wr; ifa.read_req_i = rd; ifa.data_i = d;
      n = qa.size(); cap = SA;
    end else begin
      rst_b = rst; flush_b = fl; ifb.write_req_i = wr; ifb.read_req_i = rd; ifb.data_i = d;
      n = qb.size(); cap = SB;
    end
    push = !rst && !fl && wr && (n < cap);
    pop  = !rst && !fl && rd && (n > 0);
    @(posedge clk);
    #1;
    if (u == 0) begin
      if (rst) begin
        qa.delete(); da = 8'h00;
      end else if (fl) begin
        qa.delete();
      end else begin
        if (pop) da = qa.pop_front();
        if (push) qa.push_back(d);
      end
      if (int'(ifa.count_o) > max_cnt_a) max_cnt_a = int'(ifa.count_o);
      chk("a_count", 32'(ifa.count_o), 32'(qa.size()));
      chk("a_wvalid", 32'(ifa.write_valid_o), 32'(qa.size() != SA));
      chk("a_rvalid", 32'(ifa.read_valid_o), 32'(qa.size() != 0));
      chk("a_afull", 32'(ifa.almost_full_o), 32'(qa.size() >= SA - 1));
      chk("a_aempty", 32'(ifa.almost_empty_o), 32'(qa.size() <= 1));
      chk("a_data", 32'(ifa.data_o), 32'(da));
    end else begin
      if (rst || fl) begin
        qb.delete();
      end else begin
        if (pop) void'(qb.pop_front());
        if (push) qb.push_back(d);
      end
      chk("b_count", 32'(ifb.count_o), 32'(qb.size()));
      chk("b_wvalid", 32'(ifb.write_valid_o), 32'(qb.size() != SB));
      chk("b_rvalid", 32'(ifb.read_valid_o), 32'(qb.size() != 0));
      chk("b_afull", 32'(ifb.almost_full_o), 32'(qb.size() >= 3));
      chk("b_aempty", 32'(ifb.almost_empty_o), 32'(qb.size() <= 1));
      if (qb.size() > 0) chk("b_data", 32'(ifb.data_o), 32'(qb[0]));
    end
  endtask

  initial begin
    // Reset state
    step(0, 1, 0, 0, 0, 8'h00);
    step(1, 1, 0, 0, 0, 8'h00);
    chk("rst_a_wvalid", 32'(ifa.write_valid_o), 32'd1);
    chk("rst_a_aempty", 32'(ifa.almost_empty_o), 32'd1);
    chk("rst_a_afull", 32'(ifa.almost_full_o), 32'd0);

    // Fill Size=3, then pop in order with one-cycle latency
    step(0, 0, 0, 1, 0, 8'h11);
    step(0, 0, 0, 1, 0, 8'h22);
    step(0, 0, 0, 1, 0, 8'h33);
    chk("fill_wvalid", 32'(ifa.write_valid_o), 32'd0);
    chk("fill_count", 32'(ifa.count_o), 32'd3);
    step(0, 0, 0, 1, 0, 8'h44);
    step(0, 0, 0, 0, 1, 8'h00);
    chk("pop1_data", 32'(ifa.data_o), 32'h11);
    step(0, 0, 0, 0, 1, 8'h00);
    chk("pop2_data", 32'(ifa.data_o), 32'h22);
    step(0, 0, 0, 0, 1, 8'h00);
    chk("pop3_data", 32'(ifa.data_o), 32'h33);
    chk("empty_rvalid", 32'(ifa.read_valid_o), 32'd0);
    step(0, 0, 0, 0, 1, 8'h00);
    chk("empty_pop_hold", 32'(ifa.data_o), 32'h33);

    // Simultaneous push+pop at empty and at full
    step(0, 0, 0, 1, 1, 8'h5A);
    chk("empty_pp_count", 32'(ifa.count_o), 32'd1);
    step(0, 0, 0, 1, 0, 8'h5B);
    step(0, 0, 0, 1, 0, 8'h5C);
    step(0, 0, 0, 1, 1, 8'h5D);
    chk("full_pp_count", 32'(ifa.count_o), 32'd2);
    chk("full_pp_data", 32'(ifa.data_o), 32'h5A);
    step(0, 0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 1, 8'h00);
    chk("full_pp_drop", 32'(ifa.data_o), 32'h5C);

    // Wrap: ten push/pop pairs
    max_cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1, 0, 8'(i));
      step(0, 0, 0, 0, 1, 8'h00);
      chk("wrap_order", 32'(ifa.data_o), 32'(i));
    end
    chk("wrap_max", 32'(max_cnt_a <= 3), 32'd1);

    // Flush with a concurrent write, then reset mid-fill
    step(0, 0, 0, 1, 0, 8'h05);
    step(0, 0, 0, 1, 0, 8'h06);
    step(0, 0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 0, 8'h07);
    step(0, 0, 1, 1, 0, 8'h77);
    chk("flush_count", 32'(ifa.count_o), 32'd0);
    chk("flush_data", 32'(ifa.data_o), 32'h05);
    step(0, 0, 0, 1, 0, 8'h08);
    step(0, 0, 0, 1, 0, 8'h09);
    step(0, 1, 0, 1, 0, 8'h0A);
    chk("rst_mid_count", 32'(ifa.count_o), 32'd0);
    chk("rst_mid_data", 32'(ifa.data_o), 32'd0);

    // FWFT: push visible next cycle without pop
    step(1, 0, 0, 1, 0, 8'hA5);
    chk("fwft_rvalid", 32'(ifb.read_valid_o), 32'd1);
    chk("fwft_data", 32'(ifb.data_o), 32'hA5);
    step(1, 0, 0, 0, 1, 8'h00);
    chk("fwft_pop_rvalid", 32'(ifb.read_valid_o), 32'd0);

    // Almost flags at levels 3/1
    step(1, 0, 0, 1, 0, 8'h01);
    chk("lvl1_aempty", 32'(ifb.almost_empty_o), 32'd1);
    step(1, 0, 0, 1, 0, 8'h02);
    chk("lvl2_aempty", 32'(ifb.almost_empty_o), 32'd0);
    chk("lvl2_afull", 32'(ifb.almost_full_o), 32'd0);
    step(1, 0, 0, 1, 0, 8'h03);
    chk("lvl3_afull", 32'(ifb.almost_full_o), 32'd1);

    // Randomized traffic on both configurations
    for (int i = 0; i < 400; i++)
      step(0, ($urandom % 60) == 0, ($urandom % 30) == 0, $urandom % 2, $urandom % 2,
           8'($urandom));
    for (int i = 0; i < 400; i++)
      step(1, ($urandom % 60) == 0, ($urandom % 30) == 0, $urandom % 2, $urandom % 2,
           8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
